// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Backing store on the memory side of the L1 refill/write-back port. One
// line-sized request is handled at a time:
//   - a fixed access latency is modelled after the request is accepted,
//   - a refill streams LINE_WORDS words out, one per cycle, with RValid/RIdx,
//   - a write-back absorbs LINE_WORDS words, one per cycle, selecting each
//     word from the cache via WIdx.
// Busy is the global pipeline stall. It rises combinationally in the request
// cycle itself so the pipeline freezes without a one-cycle hole.
//
// Parameters
//   LATENCY      cycles between acceptance and the first beat (>= 1)
//   LINE_WORDS   words per line (power of two, >= 2)
//   DEPTH_WORDS  storage depth in 32-bit words (power of two, >= LINE_WORDS)
//
// Ports
//   CLK       clock, all state on the rising edge
//   RESET     asynchronous, active-high reset (storage is not cleared)
//   ReqValid  request from the cache, held high until Done
//   ReqWrite  1 = write-back line, 0 = refill line (sampled at acceptance)
//   ReqAddr   byte address of the request (sampled at acceptance)
//   WData     write-back word selected by WIdx
//   WIdx      word index taken this cycle during a write burst, else 0
//   RData     refill word (holds the last beat outside a read burst)
//   RValid    RData/RIdx valid this cycle
//   RIdx      word index of RData within the line
//   Busy      stall to the cache and pipeline
//   Done      one-cycle completion pulse
//   LoadEn    backdoor preload strobe, honoured only when idle with no request
//   LoadAddr  backdoor byte address
//   LoadData  backdoor word
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int LATENCY     = 4,
   parameter int LINE_WORDS  = 4,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          ReqValid,
   input  logic                          ReqWrite,
   input  logic [31:0]                   ReqAddr,
   input  logic [31:0]                   WData,
   output logic [$clog2(LINE_WORDS)-1:0] WIdx,
   output logic [31:0]                   RData,
   output logic                          RValid,
   output logic [$clog2(LINE_WORDS)-1:0] RIdx,
   output logic                          Busy,
   output logic                          Done,
   input  logic                          LoadEn,
   input  logic [31:0]                   LoadAddr,
   input  logic [31:0]                   LoadData
);

   localparam int DATA_W = 32;
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int LINE_W = IDX_W - OFF_W;
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [CNT_W-1:0] LAT_INIT  = CNT_W'(LATENCY - 1);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RBURST,
      WBURST,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  lat_cnt;
   logic [OFF_W-1:0]  beat;
   logic [LINE_W-1:0] line;
   logic              is_write;

   // Storage starts at zero and is deliberately left out of the reset.
   logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

   logic [LINE_W-1:0] req_line;
   logic [IDX_W-1:0]  beat_addr;
   logic [IDX_W-1:0]  load_idx;
   logic              load_ok;

   // Byte offset bits and address bits above the storage depth are dropped:
   // the word index wraps silently at DEPTH_WORDS.
   assign req_line  = ReqAddr[IDX_W+1:OFF_W+2];
   assign load_idx  = LoadAddr[IDX_W+1:2];

   // Beats never wrap inside the line: base + i is just the line number
   // concatenated with the beat index.
   assign beat_addr = {line, beat};

   assign load_ok   = LoadEn && (state == IDLE) && !ReqValid;

   logic unused_addr;
   assign unused_addr = ^{ReqAddr[31:IDX_W+2], ReqAddr[OFF_W+1:0],
                          LoadAddr[31:IDX_W+2], LoadAddr[1:0]};

   // Busy must follow ReqValid combinationally while idle so the request
   // cycle itself is already stalled; DONE releases the stall.
   assign Busy = (state == WAIT) || (state == RBURST) || (state == WBURST) ||
                 ((state == IDLE) && ReqValid);

   // The cache muxes its write-back word with WIdx in the same cycle.
   assign WIdx = (state == WBURST) ? beat : '0;

   // ---------------------------------------------------------------------------
   // Control FSM with registered read-side outputs and Done
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         beat     <= '0;
         line     <= '0;
         is_write <= 1'b0;
         RValid   <= 1'b0;
         RData    <= '0;
         RIdx     <= '0;
         Done     <= 1'b0;
      end else begin
         RValid <= 1'b0;
         Done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ReqValid) begin
                  line     <= req_line;
                  is_write <= ReqWrite;
                  lat_cnt  <= LAT_INIT;
                  beat     <= '0;
                  state    <= WAIT;
               end
            end

            WAIT: begin
               if (lat_cnt == '0) begin
                  if (is_write) begin
                     state <= WBURST;
                  end else begin
                     // First refill beat is presented on the cycle RBURST
                     // starts; beat then points at the next word to fetch.
                     state  <= RBURST;
                     RValid <= 1'b1;
                     RData  <= mem[beat_addr];
                     RIdx   <= beat;
                     beat   <= beat + OFF_W'(1);
                  end
               end else begin
                  lat_cnt <= lat_cnt - CNT_W'(1);
               end
            end

            RBURST: begin
               if (RIdx == LAST_BEAT) begin
                  state <= DONE;
                  Done  <= 1'b1;
                  RIdx  <= '0;
                  beat  <= '0;
               end else begin
                  RValid <= 1'b1;
                  RData  <= mem[beat_addr];
                  RIdx   <= beat;
                  beat   <= beat + OFF_W'(1);
               end
            end

            WBURST: begin
               // The storage write for this beat happens in the memory block.
               if (beat == LAST_BEAT) begin
                  state <= DONE;
                  Done  <= 1'b1;
                  beat  <= '0;
               end else begin
                  beat <= beat + OFF_W'(1);
               end
            end

            DONE: begin
               // ReqValid is still high here; it is ignored until IDLE.
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Storage write port: write-back beats and gated backdoor preload
   // ---------------------------------------------------------------------------
   // A reset mid-burst forces state to IDLE immediately, so the beat in flight
   // is never committed while earlier beats stay in storage.
   always_ff @(posedge CLK) begin
      if (state == WBURST) begin
         mem[beat_addr] <= WData;
      end else if (load_ok) begin
         mem[load_idx] <= LoadData;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ReqValid;
   logic        ReqWrite;
   logic [31:0] ReqAddr;
   logic [31:0] WData;
   logic [1:0]  WIdx;
   logic [31:0] RData;
   logic        RValid;
   logic [1:0]  RIdx;
   logic        Busy;
   logic        Done;
   logic        LoadEn;
   logic [31:0] LoadAddr;
   logic [31:0] LoadData;

   mem_responder #(
      .LATENCY     (4),
      .LINE_WORDS  (4),
      .DEPTH_WORDS (1024)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .ReqValid (ReqValid),
      .ReqWrite (ReqWrite),
      .ReqAddr  (ReqAddr),
      .WData    (WData),
      .WIdx     (WIdx),
      .RData    (RData),
      .RValid   (RValid),
      .RIdx     (RIdx),
      .Busy     (Busy),
      .Done     (Done),
      .LoadEn   (LoadEn),
      .LoadAddr (LoadAddr),
      .LoadData (LoadData)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] model [0:1023];
   int          compared;
   int          mismatched;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] addr);
      return int'((addr >> 2) % 32'd1024);
   endfunction

   task automatic backdoor(input logic [31:0] addr, input logic [31:0] data);
      LoadEn   = 1'b1;
      LoadAddr = addr;
      LoadData = data;
      @(posedge CLK);
      #1;
      LoadEn = 1'b0;
      model[word_of(addr)] = data;
   endtask

   // One full transaction from the request cycle (cycle 0) to the cycle after
   // Done. abort_beat >= 0 pulls RESET mid-cycle during that write beat.
   task automatic run_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wbase, input int abort_beat,
                          input logic load_in_wait);
      int    base;
      int    beat;
      beat_t e;
      logic  aborted;
      logic  exp_rvalid;
      logic [31:0] last_rd;
      base    = word_of(addr) & ~3;
      aborted = 1'b0;
      last_rd = 32'h0;
      ReqValid = 1'b1;
      ReqWrite = wr;
      ReqAddr  = addr;
      if (load_in_wait) begin
         LoadEn   = 1'b1;
         LoadAddr = {addr[31:4], 4'h0};
         LoadData = 32'hDEAD_BEEF;
      end
      if (!wr) begin
         for (int i = 0; i < 4; i++) begin
            e.idx  = 2'(i);
            e.data = model[base + i];
            exp_q.push_back(e);
            last_rd = model[base + i];
         end
      end
      #1;
      check("busy_req_cycle", 32'(Busy), 32'd1);
      for (int c = 1; c <= 9 && !aborted; c++) begin
         @(posedge CLK);
         #1;
         if (c == 1) begin
            ReqAddr  = ~addr;
            ReqWrite = ~wr;
         end
         if (c == 5) LoadEn = 1'b0;
         beat = c - 5;
         exp_rvalid = !wr && beat >= 0 && beat <= 3;
         check("busy", 32'(Busy), 32'(c <= 8));
         check("done", 32'(Done), 32'(c == 9));
         check("rvalid", 32'(RValid), 32'(exp_rvalid));
         if (RValid) begin
            if (exp_q.size() == 0) begin
               check("rvalid_unexpected", 32'(RValid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ridx", 32'(RIdx), 32'(e.idx));
               check("rdata", RData, e.data);
            end
         end
         if (wr && beat >= 0 && beat <= 3) begin
            check("widx", 32'(WIdx), 32'(beat));
            WData = wbase + 32'(beat);
            if (beat == abort_beat) begin
               #2;
               RESET = 1'b1;
               #1;
               check("abort_rvalid", 32'(RValid), 32'd0);
               check("abort_done", 32'(Done), 32'd0);
               check("abort_widx", 32'(WIdx), 32'd0);
               check("abort_ridx", 32'(RIdx), 32'd0);
               check("abort_busy_req", 32'(Busy), 32'd1);
               ReqValid = 1'b0;
               #1;
               check("abort_busy_idle", 32'(Busy), 32'd0);
               @(posedge CLK);
               #1;
               RESET = 1'b0;
               for (int k = 0; k < 10; k++) begin
                  @(posedge CLK);
                  #1;
                  check("abort_no_done", 32'(Done), 32'd0);
               end
               aborted = 1'b1;
            end else begin
               model[base + beat] = wbase + 32'(beat);
            end
         end else begin
            check("widx_idle", 32'(WIdx), 32'd0);
         end
         if (c == 9) begin
            if (!wr) check("rdata_hold", RData, last_rd);
            ReqValid = 1'b0;
         end
      end
      if (!aborted) begin
         @(posedge CLK);
         #1;
         check("done_clear", 32'(Done), 32'd0);
         check("busy_idle", 32'(Busy), 32'd0);
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
      RESET    = 1'b1;
      ReqValid = 1'b0;
      ReqWrite = 1'b0;
      ReqAddr  = 32'h0;
      WData    = 32'h0;
      LoadEn   = 1'b0;
      LoadAddr = 32'h0;
      LoadData = 32'h0;

      // Reset state
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("rst_rvalid", 32'(RValid), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_ridx", 32'(RIdx), 32'd0);
      check("rst_widx", 32'(WIdx), 32'd0);
      check("rst_rdata", RData, 32'd0);
      check("rst_busy0", 32'(Busy), 32'd0);
      ReqValid = 1'b1;
      #1;
      check("rst_busy1", 32'(Busy), 32'd1);
      ReqValid = 1'b0;
      #1;
      RESET = 1'b0;
      @(posedge CLK);
      #1;

      // Refill of a preloaded line, requested at a mid-line address
      for (int i = 0; i < 4; i++) backdoor(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      run_req(1'b0, 32'h104, 32'h0, -1, 1'b0);

      // Write-back, then read the line back
      run_req(1'b1, 32'h200, 32'hB0, -1, 1'b0);
      run_req(1'b0, 32'h20C, 32'h0, -1, 1'b0);

      // Address wrap at DEPTH_WORDS aliases onto word 0
      for (int i = 0; i < 4; i++) backdoor(32'h0 + 32'(4 * i), 32'hC0 + 32'(i));
      run_req(1'b0, 32'h1000, 32'h0, -1, 1'b0);
      run_req(1'b0, 32'h0, 32'h0, -1, 1'b0);

      // Backdoor strobes during the request cycle and WAIT are ignored
      run_req(1'b0, 32'h108, 32'h0, -1, 1'b1);
      backdoor(32'h10C, 32'hA5);
      run_req(1'b0, 32'h100, 32'h0, -1, 1'b0);

      // Reset during write beat 2: beats 0 and 1 stay, 2 and 3 untouched
      for (int i = 0; i < 4; i++) backdoor(32'h300 + 32'(4 * i), 32'hD0 + 32'(i));
      run_req(1'b1, 32'h300, 32'hE0, 2, 1'b0);
      run_req(1'b0, 32'h300, 32'h0, -1, 1'b0);
      check("abort_word0", model[word_of(32'h300)], 32'hE0);
      check("abort_word2", model[word_of(32'h308)], 32'hD2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
